adder32_0_err_monitor: RTL and testbench
========================================

# adder32_0_err_monitor

Streaming error-metric accumulator that sits directly downstream of the approximate `adder32_0` partition. Each cycle it can accept one input vector together with the approximate 6-bit partition output. It recomputes the exact result for that vector and accumulates the quality metrics the approximation flow scores candidates with: mismatch count, error-distance sum and maximum, and Hamming-distance sum. Runs are bounded by a programmed sample count and end with a sticky `done`.

## Interface
- `CNT_W`, 32: width of the sample counter, `num_samples`, `sample_count`, `err_count`.
- `ACC_W`, 40: width of `ed_sum` and `hd_sum`.
- `clk`  in  1  sole clock; every register updates on its rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- `num_samples`  in  CNT_W  run length; sampled on the cycle `start` is honoured.
- `in_valid`  in  1  `in_vec` and `approx_out` carry a sample.
- `in_ready`  out  1  monitor accepts a sample this cycle.
- `in_vec`  in  11  partition inputs: [4:0]=a, [9:5]=b, [10]=cin.
- `approx_out`  in  6  approximate partition result, aligned with `in_vec`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  sticky high in DONE.
- `sample_count`  out  CNT_W  samples accumulated so far.
- `err_count`  out  CNT_W  samples with `approx_out != exact`.
- `ed_sum`  out  ACC_W  sum of |approx − exact|; saturates at all-ones.
- `ed_max`  out  6  largest single |approx − exact|.
- `hd_sum`  out  ACC_W  sum of popcount(approx ^ exact); saturates at all-ones.

## Operation
- exact = a + b + cin, 6 bits unsigned. ED = |approx_out − exact|, range 0..63. HD = popcount(approx_out ^ exact), range 0..6.
- Handshake: a sample transfers only when `in_valid && in_ready` on the same cycle. `in_ready` = (state==RUN) && (accepted < target).
- States:
  - IDLE: waits for `start`.
  - RUN: accepts samples.
  - DRAIN: waits for the pipeline to empty.
  - DONE: results held.
- Transitions:
  - IDLE/DONE + `start`: clear all metric outputs, the accepted counter and the pipeline. Latch `num_samples` as target. Go to RUN. If `num_samples`==0, go directly to DRAIN.
  - RUN: once accepted reaches target (including on the accepting cycle), go to DRAIN.
  - DRAIN: when no stage holds a valid sample, go to DONE.
  - DONE: leaves only on `start` or `rst`.
- `start` in RUN or DRAIN is ignored.
- `ed_max` updates only when the new ED is strictly greater than the stored value.
- `sample_count` and `err_count` never exceed target, so they cannot wrap.

## Timing
- Reset values: state IDLE; `in_ready`, `busy`, `done` = 0; all metric outputs = 0; pipeline valid bits = 0.
- Pipeline, 2 stages:
  - Cycle N: sample accepted.
  - Cycle N+1: stage 1 registers exact, ED and HD.
  - Cycle N+2: metric outputs show the sample.
- `done` rises 1 cycle after the final metric update, i.e. 3 cycles after the last accept. With `num_samples`==0, `done` rises 2 cycles after `start`.
- Back-to-back accepts are supported, 1 sample per cycle, with no bubbles.
- `rst` asserted mid-run: the next edge returns every register to its reset value. In-flight samples are discarded.
- `start` and `in_valid` on the same cycle in IDLE/DONE: the sample is not accepted, because `in_ready` is 0 that cycle.

## Structure
- Package `adder32_err_pkg` holds:
  - `IN_W`=11, `OUT_W`=6, `ED_W`=6, `HD_W`=3;
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - field-offset constants for a, b, cin within `in_vec`.
- Sub-module `adder32_0_exact_ref`: combinational; from `in_vec` and `approx_out` it produces exact, ED and HD. Stage 1 registers its outputs.
- Saturating adders are written inline.

## Test plan
- Reset, then `start` with `num_samples`=3. Send 3 vectors where `approx_out` equals exact (e.g. a=5, b=9, cin=0 → 14). Expect `err_count`=0, `ed_sum`=0, `hd_sum`=0, `sample_count`=3, and `done` 3 cycles after the last accept.
- a=31, b=31, cin=1 with approx=0. Exact is 63. Expect `err_count`=1, `ed_sum`=63, `ed_max`=63, `hd_sum`=6.
- Samples with ED 4, 10, 2 sent back-to-back with `in_valid` held high. Expect `ed_sum`=16 and `ed_max`=10. Expect `in_ready` to drop on the cycle after the 3rd accept.
- `num_samples`=0: expect `done`=1 two cycles after `start`, with all metrics 0.
- `num_samples`=4; assert `rst` after 2 accepts. Expect all outputs 0 and state IDLE on the next cycle. A fresh `start` must produce clean metrics.
- Force `ed_sum` near saturation with a small `ACC_W` override (`ACC_W`=6). Two samples with ED 40 must give `ed_sum`=63. `start` pulses issued during RUN must have no effect.

Source files
------------

// File: rtl/adder32_err_pkg.sv
// Shared widths, in_vec field layout and FSM state encoding for the adder32_0
// error monitor.
package adder32_err_pkg;

  localparam int IN_W    = 11;
  localparam int OUT_W   = 6;
  localparam int ED_W    = 6;
  localparam int HD_W    = 3;

  localparam int A_LSB   = 0;
  localparam int A_W     = 5;
  localparam int B_LSB   = 5;
  localparam int B_W     = 5;
  localparam int CIN_BIT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder32_0_exact_ref.sv
// Combinational golden model of the adder32_0 partition.
// Outputs the exact sum plus error distance and Hamming distance to the approximate result.
module adder32_0_exact_ref
  import adder32_err_pkg::*;
(
  input  logic [IN_W-1:0]  in_vec,
  input  logic [OUT_W-1:0] approx_out,
  output logic [OUT_W-1:0] exact,
  output logic [ED_W-1:0]  ed,
  output logic [HD_W-1:0]  hd
);

  logic [A_W-1:0]   a_s;
  logic [B_W-1:0]   b_s;
  logic             cin_s;
  logic [OUT_W-1:0] diff_s;

  // exact sum, absolute error and popcount of differing bits
  always_comb begin
    a_s    = in_vec[A_LSB +: A_W];
    b_s    = in_vec[B_LSB +: B_W];
    cin_s  = in_vec[CIN_BIT];
    exact  = OUT_W'(a_s) + OUT_W'(b_s) + OUT_W'(cin_s);
    if (approx_out >= exact) begin
      ed = ED_W'(approx_out - exact);
    end else begin
      ed = ED_W'(exact - approx_out);
    end
    diff_s = approx_out ^ exact;
    hd     = {HD_W{1'b0}};
    for (int i = 0; i < OUT_W; i++) begin
      hd = hd + HD_W'(diff_s[i]);
    end
  end

endmodule

// File: rtl/adder32_0_err_monitor.sv
// Streaming error-metric accumulator for the approximate adder32_0 partition:
// accept -> stage 1 (exact/ED/HD) -> metric registers, with a bounded-run FSM.
module adder32_0_err_monitor
  import adder32_err_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  input  logic [OUT_W-1:0] approx_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] ed_sum,
  output logic [ED_W-1:0]  ed_max,
  output logic [ACC_W-1:0] hd_sum
);

  localparam int SUM_W = ACC_W + 1;

  state_t             state_r, state_nx_s;
  logic [CNT_W-1:0]   accepted_r, accepted_nx_s;
  logic [CNT_W-1:0]   target_r, target_nx_s;
  logic               in_ready_r, ready_nx_s;
  logic               busy_r, done_r;
  logic               clear_s, accept_s;

  logic [OUT_W-1:0]   ref_exact_s;
  logic [ED_W-1:0]    ref_ed_s;
  logic [HD_W-1:0]    ref_hd_s;

  logic               s1_valid_r, s1_err_r;
  logic [ED_W-1:0]    s1_ed_r;
  logic [HD_W-1:0]    s1_hd_r;

  logic [CNT_W-1:0]   sample_count_r, err_count_r;
  logic [ACC_W-1:0]   ed_sum_r, hd_sum_r;
  logic [ED_W-1:0]    ed_max_r;
  logic [SUM_W-1:0]   ed_ext_s, hd_ext_s;
  logic [ACC_W-1:0]   ed_sum_nx_s, hd_sum_nx_s;

  assign accept_s = in_valid && in_ready_r;

  adder32_0_exact_ref u_ref (
    .in_vec     (in_vec),
    .approx_out (approx_out),
    .exact      (ref_exact_s),
    .ed         (ref_ed_s),
    .hd         (ref_hd_s)
  );

  // next-state, accept counter and target; in_ready is precomputed for next cycle
  always_comb begin
    state_nx_s    = state_r;
    accepted_nx_s = accepted_r;
    target_nx_s   = target_r;
    clear_s       = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          clear_s       = 1'b1;
          target_nx_s   = num_samples;
          accepted_nx_s = {CNT_W{1'b0}};
          if (num_samples == {CNT_W{1'b0}}) begin
            state_nx_s = DRAIN;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      RUN: begin
        accepted_nx_s = accepted_r + CNT_W'(accept_s);
        if (accepted_nx_s >= target_r) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = RUN;
        end
      end
      DRAIN: begin
        if (!s1_valid_r) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: state_nx_s = IDLE;
    endcase
    ready_nx_s = (state_nx_s == RUN) && (accepted_nx_s < target_nx_s);
  end

  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      accepted_r <= {CNT_W{1'b0}};
      target_r   <= {CNT_W{1'b0}};
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      accepted_r <= accepted_nx_s;
      target_r   <= target_nx_s;
      in_ready_r <= ready_nx_s;
      busy_r     <= (state_nx_s == RUN) || (state_nx_s == DRAIN);
      done_r     <= (state_nx_s == DONE);
    end
  end

  // stage 1: capture per-sample metrics of the accepted vector
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      s1_valid_r <= 1'b0;
      s1_err_r   <= 1'b0;
      s1_ed_r    <= {ED_W{1'b0}};
      s1_hd_r    <= {HD_W{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      s1_err_r   <= (approx_out != ref_exact_s);
      s1_ed_r    <= ref_ed_s;
      s1_hd_r    <= ref_hd_s;
    end
  end

  // saturating sums: a carry out of the ACC_W-bit field clamps to all-ones
  always_comb begin
    ed_ext_s    = {1'b0, ed_sum_r} + SUM_W'(s1_ed_r);
    hd_ext_s    = {1'b0, hd_sum_r} + SUM_W'(s1_hd_r);
    ed_sum_nx_s = ed_ext_s[ACC_W] ? {ACC_W{1'b1}} : ed_ext_s[ACC_W-1:0];
    hd_sum_nx_s = hd_ext_s[ACC_W] ? {ACC_W{1'b1}} : hd_ext_s[ACC_W-1:0];
  end

  // metric accumulators
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      sample_count_r <= {CNT_W{1'b0}};
      err_count_r    <= {CNT_W{1'b0}};
      ed_sum_r       <= {ACC_W{1'b0}};
      hd_sum_r       <= {ACC_W{1'b0}};
      ed_max_r       <= {ED_W{1'b0}};
    end else if (s1_valid_r) begin
      sample_count_r <= sample_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      err_count_r    <= err_count_r + CNT_W'(s1_err_r);
      ed_sum_r       <= ed_sum_nx_s;
      hd_sum_r       <= hd_sum_nx_s;
      if (s1_ed_r > ed_max_r) begin
        ed_max_r <= s1_ed_r;
      end else begin
        ed_max_r <= ed_max_r;
      end
    end else begin
      sample_count_r <= sample_count_r;
      err_count_r    <= err_count_r;
      ed_sum_r       <= ed_sum_r;
      hd_sum_r       <= hd_sum_r;
      ed_max_r       <= ed_max_r;
    end
  end

  assign in_ready     = in_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign sample_count = sample_count_r;
  assign err_count    = err_count_r;
  assign ed_sum       = ed_sum_r;
  assign ed_max       = ed_max_r;
  assign hd_sum       = hd_sum_r;

endmodule

// File: tb/tb_adder32_0_err_monitor.sv
// Self-checking bench: a default-width monitor and an ACC_W=6 copy share stimulus;
// a sample-level model predicts every output each cycle, plus literal spot checks.
module tb_adder32_0_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid;
  logic [31:0] num_samples;
  logic [10:0] in_vec;
  logic [5:0]  approx_out;

  logic        rdy, busy, done;
  logic [31:0] sc, ec;
  logic [39:0] eds, hds;
  logic [5:0]  edm;

  logic        s_rdy, s_busy, s_done;
  logic [31:0] s_sc, s_ec;
  logic [5:0]  s_eds, s_hds, s_edm;

  adder32_0_err_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(rdy), .in_vec(in_vec), .approx_out(approx_out),
    .busy(busy), .done(done), .sample_count(sc), .err_count(ec),
    .ed_sum(eds), .ed_max(edm), .hd_sum(hds)
  );

  adder32_0_err_monitor #(.CNT_W(32), .ACC_W(6)) u_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_rdy), .in_vec(in_vec), .approx_out(approx_out),
    .busy(s_busy), .done(s_done), .sample_count(s_sc), .err_count(s_ec),
    .ed_sum(s_eds), .ed_max(s_edm), .hd_sum(s_hds)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model: run phase 0=idle 1=run 2=drain 3=done; samples land two edges after accept
  int     m_phase;
  longint m_acc, m_tgt, m_sc, m_ec, m_eds, m_hds;
  int     m_edm;
  bit     m_pv, m_perr, m_acc_flag;
  int     m_ped, m_phd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sat6(input longint v);
    return (v > 63) ? 63 : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_acc = 0; m_tgt = 0; m_sc = 0; m_ec = 0; m_eds = 0; m_hds = 0;
        m_edm = 0; m_pv = 0; m_perr = 0; m_ped = 0; m_phd = 0; m_acc_flag = 0;
      end else begin
        bit acc, old_pv;
        int ex, ap;
        acc = (m_phase == 1) && (m_acc < m_tgt) && in_valid;
        m_acc_flag = acc;
        old_pv = m_pv;
        if (m_pv) begin
          m_sc++;
          if (m_perr) m_ec++;
          m_eds += m_ped;
          m_hds += m_phd;
          if (m_ped > m_edm) m_edm = m_ped;
        end
        m_pv = acc;
        if (acc) begin
          ex = int'(in_vec[4:0]) + int'(in_vec[9:5]) + int'(in_vec[10]);
          ap = int'(approx_out);
          m_ped  = (ap > ex) ? ap - ex : ex - ap;
          m_perr = (ap != ex);
          m_phd  = $countones(approx_out ^ 6'(ex));
        end
        if ((m_phase == 0 || m_phase == 3) && start) begin
          m_sc = 0; m_ec = 0; m_eds = 0; m_hds = 0; m_edm = 0; m_pv = 0;
          m_tgt = num_samples; m_acc = 0;
          m_phase = (num_samples == 0) ? 2 : 1;
        end else if (m_phase == 1) begin
          if (acc) m_acc++;
          if (m_acc >= m_tgt) m_phase = 2;
        end else if (m_phase == 2) begin
          if (!old_pv) m_phase = 3;
        end
      end
    end
  end

  // per-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", rdy,  (m_phase == 1) && (m_acc < m_tgt));
      chk("busy",     busy, (m_phase == 1) || (m_phase == 2));
      chk("done",     done, m_phase == 3);
      chk("sample_count", sc, m_sc);
      chk("err_count",    ec, m_ec);
      chk("ed_sum",       eds, m_eds);
      chk("ed_max",       edm, m_edm);
      chk("hd_sum",       hds, m_hds);
      chk("sat_in_ready", s_rdy,  (m_phase == 1) && (m_acc < m_tgt));
      chk("sat_done",     s_done, m_phase == 3);
      chk("sat_busy",     s_busy, (m_phase == 1) || (m_phase == 2));
      chk("sat_sample_count", s_sc, m_sc);
      chk("sat_err_count",    s_ec, m_ec);
      chk("sat_ed_sum",       s_eds, sat6(m_eds));
      chk("sat_ed_max",       s_edm, m_edm);
      chk("sat_hd_sum",       s_hds, sat6(m_hds));
    end
  end

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    num_samples = 32'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // present a sample and hold it until it is accepted; leaves in_valid high
  task automatic send(input int a, input int b, input int cin, input int ap);
    bit got;
    in_vec     = {1'(cin), 5'(b), 5'(a)};
    approx_out = 6'(ap);
    in_valid   = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = m_acc_flag;
    end
    if (!got) chk("accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !done; k++) @(negedge clk);
    chk("done_wait", done, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = 32'd0;
    in_vec = 11'd0; approx_out = 6'd0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready", rdy, 64'd0);
    chk("rst_done", done, 64'd0);
    chk("rst_ed_sum", eds, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // exact samples only
    do_start(3);
    send(5, 9, 0, 14);
    send(1, 2, 1, 4);
    send(31, 0, 0, 31);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_done_early", done, 64'd0);
    @(negedge clk);
    chk("t1_done_n3", done, 64'd1);
    chk("t1_sc", sc, 64'd3);
    chk("t1_ec", ec, 64'd0);
    chk("t1_eds", eds, 64'd0);
    chk("t1_hds", hds, 64'd0);

    // worst-case sample; in_valid raised together with start is not taken
    in_vec = {1'b1, 5'd31, 5'd31}; approx_out = 6'd0; in_valid = 1'b1;
    do_start(1);
    chk("t2_no_early_accept", sc, 64'd0);
    send(31, 31, 1, 0);
    in_valid = 1'b0;
    wait_done();
    chk("t2_ec", ec, 64'd1);
    chk("t2_eds", eds, 64'd63);
    chk("t2_edm", edm, 64'd63);
    chk("t2_hds", hds, 64'd6);
    chk("t2_sc", sc, 64'd1);

    // ED 4, 10, 2 back to back
    do_start(3);
    send(5, 9, 0, 18);
    send(5, 9, 0, 4);
    chk("t3_ready_mid", rdy, 64'd1);
    send(5, 9, 0, 12);
    chk("t3_ready_drop", rdy, 64'd0);
    in_valid = 1'b0;
    wait_done();
    chk("t3_eds", eds, 64'd16);
    chk("t3_edm", edm, 64'd10);
    chk("t3_hds", hds, 64'd6);
    chk("t3_ec", ec, 64'd3);

    // zero-length run
    @(negedge clk);
    start = 1'b1; num_samples = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("t4_done_s1", done, 64'd0);
    @(negedge clk);
    chk("t4_done_s2", done, 64'd1);
    chk("t4_sc", sc, 64'd0);
    chk("t4_eds", eds, 64'd0);

    // reset mid-run, then a clean run
    do_start(4);
    send(3, 3, 0, 9);
    send(3, 3, 0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", busy, 64'd0);
    chk("t5_ready", rdy, 64'd0);
    chk("t5_sc", sc, 64'd0);
    chk("t5_eds", eds, 64'd0);
    do_start(2);
    send(7, 8, 1, 16);
    send(0, 0, 0, 0);
    in_valid = 1'b0;
    wait_done();
    chk("t5_clean_sc", sc, 64'd2);
    chk("t5_clean_ec", ec, 64'd0);
    chk("t5_clean_eds", eds, 64'd0);

    // saturation on the narrow copy; start during RUN ignored
    do_start(2);
    send(0, 0, 0, 40);
    in_valid = 1'b0;
    start = 1'b1; num_samples = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("t6_still_busy", busy, 64'd1);
    send(0, 0, 0, 40);
    in_valid = 1'b0;
    wait_done();
    chk("t6_sat_eds", s_eds, 64'd63);
    chk("t6_wide_eds", eds, 64'd80);
    chk("t6_sat_hds", s_hds, 64'd4);
    chk("t6_sc", sc, 64'd2);
    chk("t6_edm", edm, 64'd40);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
